// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe
//   Pipelined RV32 control decoder. Decodes opcode/funct3/funct7 in ID and
//   carries the control bundle through the ID/EX, EX/MEM and MEM/WB
//   registers. It also detects load-use hazards, inserts bubbles, flushes
//   ID/EX on a taken branch/jump, and freezes every stage on a global hold.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   id_valid                IF/ID holds a real instruction
//   opcode/funct3/funct7    instruction fields in ID
//   rs1/rs2/rd              register addresses in ID
//   hold                    downstream busy, freezes all stages
//   flush                   branch/jump taken in EX, kills the ID instruction
//   id_stall                load-use stall request to PC and IF/ID
//   id_illegal              combinational, valid instruction with unknown opcode
//   ex_*                    EX stage control bundle
//   mem_*                   MEM stage control bundle
//   wb_*                    WB stage control bundle
// ---------------------------------------------------------------------------
module ctrl_pipe #(
  parameter int         ALU_CW    = 4,
  parameter int         REG_AW    = 5,
  parameter logic [6:0] OP_BRANCH = 7'b1001011,
  parameter logic [6:0] OP_JALR   = 7'b1001111,
  parameter bit         HAZARD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              hold,
  input  logic              flush,
  output logic              id_stall,
  output logic              id_illegal,
  output logic              ex_valid,
  output logic [ALU_CW-1:0] ex_alu_ctrl,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] wb_rd
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [ALU_CW-1:0] ALU_ADD   = ALU_CW'(0);
  localparam logic [ALU_CW-1:0] ALU_SUB   = ALU_CW'(1);
  localparam logic [ALU_CW-1:0] ALU_AND   = ALU_CW'(2);
  localparam logic [ALU_CW-1:0] ALU_OR    = ALU_CW'(3);
  localparam logic [ALU_CW-1:0] ALU_XOR   = ALU_CW'(4);
  localparam logic [ALU_CW-1:0] ALU_SLL   = ALU_CW'(5);
  localparam logic [ALU_CW-1:0] ALU_SRL   = ALU_CW'(6);
  localparam logic [ALU_CW-1:0] ALU_SRA   = ALU_CW'(7);
  localparam logic [ALU_CW-1:0] ALU_SLT   = ALU_CW'(8);
  localparam logic [ALU_CW-1:0] ALU_SLTU  = ALU_CW'(9);
  localparam logic [ALU_CW-1:0] ALU_PASSB = ALU_CW'(10);

  typedef struct packed {
    logic              valid;
    logic [ALU_CW-1:0] alu_ctrl;
    logic              alusrc;
    logic              branch;
    logic              jump;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        funct3;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        funct3;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rd;
  } wb_ctrl_t;

  ex_ctrl_t  dec;
  ex_ctrl_t  ex_q;
  mem_ctrl_t mem_q;
  wb_ctrl_t  wb_q;
  logic      legal;
  logic      uses_rs1;
  logic      uses_rs2;
  logic      load_use;

  // Only funct7[5] carries meaning for this decoder.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // funct7[5] picks SUB only for register-register ops; SRA for both forms.
  function automatic logic [ALU_CW-1:0] alu_sel(input logic [2:0] f3,
                                                input logic       f7b5,
                                                input logic       is_r);
    logic [ALU_CW-1:0] code;
    case (f3)
      3'd0:    code = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1:    code = ALU_SLL;
      3'd2:    code = ALU_SLT;
      3'd3:    code = ALU_SLTU;
      3'd4:    code = ALU_XOR;
      3'd5:    code = f7b5 ? ALU_SRA : ALU_SRL;
      3'd6:    code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  // ID-stage decode. Unknown opcodes and empty IF/ID slots become bubbles.
  always_comb begin
    dec      = '0;
    legal    = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        dec.alu_ctrl  = alu_sel(funct3, funct7[5], 1'b1);
        dec.reg_write = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_IALU: begin
        dec.alu_ctrl  = alu_sel(funct3, funct7[5], 1'b0);
        dec.alusrc    = 1'b1;
        dec.reg_write = 1'b1;
        uses_rs1      = 1'b1;
      end
      OP_LOAD: begin
        dec.alusrc     = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.funct3     = funct3;
        uses_rs1       = 1'b1;
      end
      OP_STORE: begin
        dec.alusrc    = 1'b1;
        dec.mem_write = 1'b1;
        dec.funct3    = funct3;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      OP_JALR: begin
        dec.jump      = 1'b1;
        dec.alusrc    = 1'b1;
        dec.reg_write = 1'b1;
        uses_rs1      = 1'b1;
      end
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        dec.alusrc    = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_LUI: begin
        dec.alusrc    = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = ALU_PASSB;
      end
      default: legal = 1'b0;
    endcase

    // x0 is never written; loads still read memory so faults/side effects stay.
    if (rd == '0) begin
      dec.reg_write = 1'b0;
    end
    dec.rd    = rd;
    dec.valid = 1'b1;

    if (!(id_valid && legal)) begin
      dec      = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end

  assign id_illegal = id_valid & ~legal;

  // A load in EX whose result a dependent ID instruction needs next cycle.
  assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                    (((ex_q.rd == rs1) & uses_rs1) | ((ex_q.rd == rs2) & uses_rs2));

  // Hold and flush both override the stall request.
  assign id_stall = HAZARD_EN & id_valid & load_use & ~flush & ~hold;

  // Pipeline registers. Hold freezes everything; flush or stall replaces the
  // ID instruction with a bubble while older stages keep moving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!hold) begin
      ex_q <= (flush || id_stall) ? '0 : dec;

      mem_q.valid      <= ex_q.valid;
      mem_q.mem_read   <= ex_q.mem_read;
      mem_q.mem_write  <= ex_q.mem_write;
      mem_q.funct3     <= ex_q.funct3;
      mem_q.reg_write  <= ex_q.reg_write;
      mem_q.mem_to_reg <= ex_q.mem_to_reg;
      mem_q.rd         <= ex_q.rd;

      wb_q.valid      <= mem_q.valid;
      wb_q.reg_write  <= mem_q.reg_write;
      wb_q.mem_to_reg <= mem_q.mem_to_reg;
      wb_q.rd         <= mem_q.rd;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_alu_ctrl = ex_q.alu_ctrl;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_branch   = ex_q.branch;
  assign ex_jump     = ex_q.jump;
  assign ex_rd       = ex_q.rd;
  assign mem_valid   = mem_q.valid;
  assign mem_read    = mem_q.mem_read;
  assign mem_write   = mem_q.mem_write;
  assign mem_funct3  = mem_q.funct3;
  assign wb_valid    = wb_q.valid;
  assign wb_regwrite = wb_q.reg_write;
  assign wb_memtoreg = wb_q.mem_to_reg;
  assign wb_rd       = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe
//   Directed bench for ctrl_pipe. Each step drives one ID-stage instruction,
//   pushes the bundle it should produce in EX into a queue, and after the
//   clock edge pops it and ages the previous expectations into MEM and WB.
//   A second instance with HAZARD_EN=0 shares the inputs and must never stall.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1001011;
  localparam logic [6:0] OP_JALR  = 7'b1001111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       mrd;
    logic       mwr;
    logic [2:0] f3;
    logic       rw;
    logic       m2r;
    logic [4:0] rd;
  } bundle_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;
  logic       hold, flush;

  logic       id_stall, id_illegal, ex_valid, ex_alusrc, ex_branch, ex_jump;
  logic [3:0] ex_alu_ctrl;
  logic [4:0] ex_rd, wb_rd;
  logic       mem_valid, mem_read, mem_write, wb_valid, wb_regwrite, wb_memtoreg;
  logic [2:0] mem_funct3;

  logic       nh_id_stall;
  logic       unused_nh_ill, unused_nh_exv, unused_nh_alusrc, unused_nh_br, unused_nh_jmp;
  logic [3:0] unused_nh_alu;
  logic [4:0] unused_nh_exrd, unused_nh_wbrd;
  logic       unused_nh_memv, unused_nh_mrd, unused_nh_mwr;
  logic       unused_nh_wbv, unused_nh_rw, unused_nh_m2r;
  logic [2:0] unused_nh_f3;

  int tests_run    = 0;
  int tests_failed = 0;

  bundle_t exp_q[$];
  bundle_t cur_ex, cur_mem, cur_wb;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .hold(hold), .flush(flush), .id_stall(id_stall), .id_illegal(id_illegal),
    .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_alusrc(ex_alusrc),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd)
  );

  ctrl_pipe #(.HAZARD_EN(1'b0)) dut_nohaz (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .hold(hold), .flush(flush), .id_stall(nh_id_stall), .id_illegal(unused_nh_ill),
    .ex_valid(unused_nh_exv), .ex_alu_ctrl(unused_nh_alu), .ex_alusrc(unused_nh_alusrc),
    .ex_branch(unused_nh_br), .ex_jump(unused_nh_jmp), .ex_rd(unused_nh_exrd),
    .mem_valid(unused_nh_memv), .mem_read(unused_nh_mrd), .mem_write(unused_nh_mwr),
    .mem_funct3(unused_nh_f3), .wb_valid(unused_nh_wbv), .wb_regwrite(unused_nh_rw),
    .wb_memtoreg(unused_nh_m2r), .wb_rd(unused_nh_wbrd)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts, and reports any disagreement.
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BR, OP_JALR,
                      OP_JAL, OP_AUIPC, OP_LUI};
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BR, OP_JALR};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BR};
  endfunction

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7b5,
                                         input logic is_r);
    case (f3)
      3'd0:    return (is_r && f7b5) ? 4'd1 : 4'd0;
      3'd1:    return 4'd5;
      3'd2:    return 4'd8;
      3'd3:    return 4'd9;
      3'd4:    return 4'd4;
      3'd5:    return f7b5 ? 4'd7 : 4'd6;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Reference decode written from the opcode table.
  function automatic bundle_t ref_decode(input logic v, input logic [6:0] op,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [4:0] rdv);
    bundle_t b = '0;
    if (!v || !is_legal(op)) return b;
    b.valid = 1'b1;
    b.rd    = rdv;
    case (op)
      OP_R:     begin b.alu = ref_alu(f3, f7[5], 1'b1); b.rw = 1'b1; end
      OP_IALU:  begin b.alu = ref_alu(f3, f7[5], 1'b0); b.alusrc = 1'b1; b.rw = 1'b1; end
      OP_LOAD:  begin b.alusrc = 1'b1; b.mrd = 1'b1; b.m2r = 1'b1; b.rw = 1'b1; b.f3 = f3; end
      OP_STORE: begin b.alusrc = 1'b1; b.mwr = 1'b1; b.f3 = f3; end
      OP_BR:    begin b.branch = 1'b1; b.alu = 4'd1; end
      OP_JALR:  begin b.jump = 1'b1; b.alusrc = 1'b1; b.rw = 1'b1; end
      OP_JAL:   begin b.jump = 1'b1; b.rw = 1'b1; end
      OP_AUIPC: begin b.alusrc = 1'b1; b.rw = 1'b1; b.alu = 4'd0; end
      default:  begin b.alusrc = 1'b1; b.rw = 1'b1; b.alu = 4'd10; end
    endcase
    if (rdv == 5'd0) b.rw = 1'b0;
    return b;
  endfunction

  task automatic check_output();
    cmp("ex_valid",    ex_valid,    cur_ex.valid);
    cmp("ex_alu_ctrl", ex_alu_ctrl, cur_ex.alu);
    cmp("ex_alusrc",   ex_alusrc,   cur_ex.alusrc);
    cmp("ex_branch",   ex_branch,   cur_ex.branch);
    cmp("ex_jump",     ex_jump,     cur_ex.jump);
    cmp("ex_rd",       ex_rd,       cur_ex.rd);
    cmp("mem_valid",   mem_valid,   cur_mem.valid);
    cmp("mem_read",    mem_read,    cur_mem.mrd);
    cmp("mem_write",   mem_write,   cur_mem.mwr);
    cmp("mem_funct3",  mem_funct3,  cur_mem.f3);
    cmp("wb_valid",    wb_valid,    cur_wb.valid);
    cmp("wb_regwrite", wb_regwrite, cur_wb.rw);
    cmp("wb_memtoreg", wb_memtoreg, cur_wb.m2r);
    cmp("wb_rd",       wb_rd,       cur_wb.rd);
  endtask

  // One ID-stage cycle: drive at the falling edge, check the combinational
  // outputs, clock, then check every stage against the aged expectations.
  task automatic apply_stimulus(input logic v, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rdv, input logic h,
                                input logic fl);
    logic exp_stall;
    logic exp_ill;
    id_valid = v; opcode = op; funct3 = f3; funct7 = f7;
    rs1 = r1; rs2 = r2; rd = rdv; hold = h; flush = fl;
    #1;
    exp_ill   = v && !is_legal(op);
    exp_stall = v && !h && !fl && cur_ex.valid && cur_ex.mrd && (cur_ex.rd != 5'd0) &&
                (((cur_ex.rd == r1) && reads_rs1(op)) || ((cur_ex.rd == r2) && reads_rs2(op)));
    cmp("id_illegal", id_illegal, exp_ill);
    cmp("id_stall", id_stall, exp_stall);
    cmp("nohaz_id_stall", nh_id_stall, 1'b0);
    if (!h) exp_q.push_back((fl || exp_stall) ? bundle_t'('0) : ref_decode(v, op, f3, f7, rdv));
    @(posedge clk);
    #1;
    if (!h) begin
      cur_wb  = cur_mem;
      cur_mem = cur_ex;
      cur_ex  = exp_q.pop_front();
    end
    check_output();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    rs1 = '0; rs2 = '0; rd = '0; hold = 1'b0; flush = 1'b0;
    cur_ex = '0; cur_mem = '0; cur_wb = '0;
    @(negedge clk);
    check_output();
    rst_n = 1'b1;

    // Main decode sequence, one instruction per cycle.
    apply_stimulus(1'b1, OP_R,     3'd0, 7'h00, 5'd2, 5'd3, 5'd1, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_IALU,  3'd6, 7'h00, 5'd1, 5'd0, 5'd2, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_LOAD,  3'd2, 7'h00, 5'd1, 5'd0, 5'd3, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_STORE, 3'd1, 7'h00, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_BR,    3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_JALR,  3'd0, 7'h00, 5'd2, 5'd0, 5'd1, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_JAL,   3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_AUIPC, 3'd0, 7'h00, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_LUI,   3'd0, 7'h00, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_R,     3'd0, 7'h20, 5'd2, 5'd3, 5'd8, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_IALU,  3'd5, 7'h20, 5'd2, 5'd0, 5'd9, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_IALU,  3'd0, 7'h20, 5'd2, 5'd0, 5'd9, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_R,     3'd3, 7'h00, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0);
    idle(3);

    // Load-use: stall one cycle, upstream re-presents the add.
    apply_stimulus(1'b1, OP_LOAD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_R,    3'd0, 7'h00, 5'd5, 5'd6, 5'd9, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_R,    3'd0, 7'h00, 5'd5, 5'd6, 5'd9, 1'b0, 1'b0);
    // rs2 side of the hazard through a store.
    apply_stimulus(1'b1, OP_LOAD,  3'd0, 7'h00, 5'd1, 5'd0, 5'd4, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_STORE, 3'd0, 7'h00, 5'd2, 5'd4, 5'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_STORE, 3'd0, 7'h00, 5'd2, 5'd4, 5'd0, 1'b0, 1'b0);
    // No stall: load to x0, and a consumer that reads no registers.
    apply_stimulus(1'b1, OP_LOAD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_R,    3'd0, 7'h00, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_LOAD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_JAL,  3'd0, 7'h00, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0);
    idle(3);

    // Flush masks a pending load-use stall; the load keeps moving.
    apply_stimulus(1'b1, OP_LOAD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_R,    3'd0, 7'h00, 5'd5, 5'd6, 5'd9, 1'b0, 1'b1);
    apply_stimulus(1'b1, OP_BR,   3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_IALU, 3'd0, 7'h00, 5'd1, 5'd0, 5'd2, 1'b0, 1'b1);
    idle(3);

    // Hold with flush asserted freezes everything, then flush takes effect.
    apply_stimulus(1'b1, OP_LOAD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_R,    3'd0, 7'h00, 5'd7, 5'd1, 5'd8, 1'b1, 1'b1);
    apply_stimulus(1'b1, OP_R,    3'd0, 7'h00, 5'd7, 5'd1, 5'd8, 1'b1, 1'b1);
    apply_stimulus(1'b1, OP_R,    3'd0, 7'h00, 5'd7, 5'd1, 5'd8, 1'b1, 1'b1);
    apply_stimulus(1'b1, OP_LUI,  3'd0, 7'h00, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1);
    apply_stimulus(1'b1, OP_LUI,  3'd0, 7'h00, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);

    // Undefined opcode, valid and invalid.
    apply_stimulus(1'b1, 7'b1111111, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    apply_stimulus(1'b0, 7'b1111111, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);

    // Asynchronous reset between edges with a full pipeline.
    apply_stimulus(1'b1, OP_LOAD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd3, 1'b0, 1'b0);
    apply_stimulus(1'b1, OP_IALU, 3'd6, 7'h00, 5'd1, 5'd0, 5'd2, 1'b0, 1'b0);
    id_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    cur_ex = '0; cur_mem = '0; cur_wb = '0;
    exp_q.delete();
    check_output();
    @(negedge clk);
    check_output();
    rst_n = 1'b1;
    apply_stimulus(1'b1, OP_R, 3'd0, 7'h00, 5'd2, 5'd3, 5'd1, 1'b0, 1'b0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised, pipelined successor to the combinational RV32 control decoder.
- Decodes opcode/funct3/funct7 in ID and carries the resulting control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Adds load-use hazard detection, bubble insertion, branch flush and a global hold.
- Sits between the IF/ID register and the datapath stage muxes.

Parameters:
- ALU_CW, 4: width of the ALU control code.
- REG_AW, 5: register address width.
- OP_BRANCH, 7'b1001011: branch opcode (codebase encoding).
- OP_JALR, 7'b1001111: jalr opcode (codebase encoding).
- HAZARD_EN, 1: 1 enables load-use detection; 0 forces id_stall to 0.

Ports:
- clk in 1: clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- id_valid in 1: IF/ID holds a real instruction.
- opcode in 7: instruction opcode.
- funct3 in 3: instruction funct3.
- funct7 in 7: instruction funct7.
- rs1 in REG_AW: source register 1 address.
- rs2 in REG_AW: source register 2 address.
- rd in REG_AW: destination register address.
- hold in 1: downstream busy; freezes all stages.
- flush in 1: branch/jump taken in EX.
- id_stall out 1: load-use stall request to PC and IF/ID.
- id_illegal out 1: combinational; id_valid high with an undefined opcode.
- ex_valid out 1: EX stage valid.
- ex_alu_ctrl out ALU_CW: EX ALU operation.
- ex_alusrc out 1: EX ALU B-source select.
- ex_branch out 1: EX branch.
- ex_jump out 1: EX jump.
- ex_rd out REG_AW: EX destination register.
- mem_valid out 1: MEM stage valid.
- mem_read out 1: MEM load.
- mem_write out 1: MEM store.
- mem_funct3 out 3: MEM access size.
- wb_valid out 1: WB stage valid.
- wb_regwrite out 1: WB register write.
- wb_memtoreg out 1: WB result source.
- wb_rd out REG_AW: WB destination register.

Behaviour:
- Reset: every registered output is 0, asynchronously. The pipeline holds bubbles only.
- Decode table (combinational, ID stage):
  - R 0110011: alusrc=0, regwrite=1.
  - I-ALU 0010011: alusrc=1, regwrite=1.
  - Load 0000011: alusrc=1, memread=1, memtoreg=1, regwrite=1.
  - Store 0100011: alusrc=1, memwrite=1.
  - OP_BRANCH: branch=1, alu=SUB.
  - OP_JALR: jump=1, alusrc=1, regwrite=1.
  - JAL 1101111: jump=1, regwrite=1.
  - AUIPC 0010111: alusrc=1, regwrite=1, alu=ADD.
  - LUI 0110111: alusrc=1, regwrite=1, alu=PASSB.
- ALU codes:
  - Values: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB 10.
  - Selected from funct3. funct7[5] selects SUB/SRA for R-type; for I-type it selects SRA only.
  - Codes are zero-extended when ALU_CW > 4.
- regwrite is forced to 0 when rd==0. Loads keep memread=1 regardless of rd.
- Any undefined opcode: id_illegal=1 and decodes as a bubble (all controls 0, valid 0).
- Latency: instruction in ID at cycle N appears on ex_* at N+1, mem_* at N+2, wb_* at N+3.
- Load-use hazard:
  - id_stall = HAZARD_EN & id_valid & ex_valid & EX-is-load & ex_rd!=0 & (ex_rd==rs1 & op uses rs1, or ex_rd==rs2 & op uses rs2).
  - rs1 is used by R, I-ALU, load, store, branch, jalr. rs2 is used by R, store, branch.
  - While id_stall: ID/EX loads a bubble; EX/MEM and MEM/WB advance; upstream holds ID. The stall lasts exactly 1 cycle.
- Flush: ID/EX loads a bubble. The instruction in EX (the branch) still advances to MEM. id_stall is masked to 0 while flush is asserted.
- Hold: highest priority. All three pipeline registers keep their value and id_stall is forced to 0. flush is ignored while hold is high, so the source keeps flush asserted until hold drops.
- Priority: reset > hold > flush > stall > normal advance.
- An invalid stage has all controls 0. The valid bit travels with its bundle.

Test Plan:
- Reset: rst_n=0 mid-stream (async, between edges) -> all outputs 0 immediately; first valid add after release appears at ex 1 cycle later with ex_alu_ctrl=0.
- Sequence add, ori(funct3=6), load, store, OP_BRANCH, OP_JALR, jal, auipc, each one cycle:
  - ex_alu_ctrl: ori gives 3, branch gives 1.
  - mem_read=1 at N+2 for the load; mem_write=1 at N+2 for the store.
  - wb_regwrite and wb_memtoreg follow at N+3.
- Load-use: load rd=5, then add rs1=5 -> id_stall=1 for one cycle; ex_valid=0 on the next cycle; add reaches ex one cycle late; with HAZARD_EN=0, no stall.
- Load rd=0 followed by add rs1=0 -> no stall. Load rd=5 followed by jal -> no stall.
- Flush with a load-use condition pending -> id_stall=0; ex_valid=0 next cycle; branch bundle appears on mem_* next cycle.
- hold=1 for 3 cycles with flush=1 -> all outputs frozen; after hold drops with flush still 1, ex bubble inserted. Undefined opcode 7'b1111111 -> id_illegal=1, ex_valid=0 next cycle.
